// File: rtl/ebpc_pkg.sv
// Shared EBPC decoder definitions: stream word width, unpacker window size,
// unpacker state encoding and a counter-width helper.
package ebpc_pkg;

  localparam int DATA_W       = 8;
  localparam int UNPK_MAX_LEN = 16;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } unpk_state_e;

  // Bits needed to hold any value in 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bpc_funnel_shift.sv
// Combinational buffer update: drop shift_i consumed bits off the top, then
// OR an optional input word in directly below the pos_i bits that remain.
module bpc_funnel_shift #(
  parameter int BUF_W = 24,
  parameter int IN_W  = 8,
  parameter int SH_W  = 5
) (
  input  logic [BUF_W-1:0] buf_i,
  input  logic [SH_W-1:0]  shift_i,
  input  logic [SH_W-1:0]  pos_i,
  input  logic [IN_W-1:0]  word_i,
  input  logic             push_i,
  output logic [BUF_W-1:0] buf_o
);

  logic [BUF_W-1:0] shifted;
  logic [BUF_W-1:0] word_aligned;

  // The buffer is zero below its fill level, so an OR is enough to insert.
  always_comb begin
    shifted      = buf_i << shift_i;
    word_aligned = '0;
    if (push_i) begin
      word_aligned = {word_i, {(BUF_W - IN_W){1'b0}}} >> pos_i;
    end
    buf_o = shifted | word_aligned;
  end

endmodule

// File: rtl/bpc_bit_unpacker.sv
// Variable-rate bit unpacker: fixed-width words in, MSB-first bit window out,
// with stream framing, a drain phase and sticky over-consumption detection.
module bpc_bit_unpacker
  import ebpc_pkg::*;
#(
  parameter int IN_W    = DATA_W,
  parameter int MAX_LEN = UNPK_MAX_LEN,
  parameter int BUF_W   = MAX_LEN + IN_W,
  parameter int FILL_W  = cnt_w(BUF_W),
  parameter int LEN_W   = cnt_w(MAX_LEN)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic [IN_W-1:0]    data_i,
  input  logic               vld_i,
  input  logic               last_i,
  output logic               rdy_o,
  output logic [MAX_LEN-1:0] data_o,
  output logic [FILL_W-1:0]  fill_o,
  output logic               vld_o,
  output logic               last_o,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               rdy_i,
  output logic               err_o
);

  localparam logic [FILL_W-1:0] MAX_F = FILL_W'(MAX_LEN);
  localparam logic [FILL_W-1:0] IN_F  = FILL_W'(IN_W);

  unpk_state_e       state_q, state_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              err_q, err_d;

  logic              abort;
  logic              push;
  logic              hs;
  logic              over;
  logic [FILL_W-1:0] len_ext;
  logic [FILL_W-1:0] cons;
  logic [FILL_W-1:0] fill_rem;

  // Accepting only at fill <= MAX_LEN keeps fill within BUF_W after a push.
  always_comb begin
    abort    = rst_i | clr_i;
    rdy_o    = !abort && (state_q != DRAIN) && (fill_q <= MAX_F);
    vld_o    = !abort && ((fill_q >= MAX_F) || ((state_q == DRAIN) && (fill_q != '0)));
    last_o   = vld_o && (state_q == DRAIN) && (fill_q <= MAX_F);
    data_o   = buf_q[BUF_W-1 -: MAX_LEN];
    fill_o   = fill_q;
    err_o    = err_q;

    push     = vld_i && rdy_o;
    hs       = vld_o && rdy_i;
    len_ext  = FILL_W'(len_i);
    over     = hs && (len_ext > fill_q);
    cons     = '0;
    if (hs) begin
      cons = over ? fill_q : len_ext;
    end
    fill_rem = fill_q - cons;
    fill_d   = fill_rem + (push ? IN_F : '0);
    err_d    = err_q | over;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, STREAM: begin
        if (push) begin
          state_d = last_i ? DRAIN : STREAM;
        end
      end
      DRAIN: begin
        if (fill_d == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  bpc_funnel_shift #(
    .BUF_W (BUF_W),
    .IN_W  (IN_W),
    .SH_W  (FILL_W)
  ) u_funnel (
    .buf_i   (buf_q),
    .shift_i (cons),
    .pos_i   (fill_rem),
    .word_i  (data_i),
    .push_i  (push),
    .buf_o   (buf_d)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      state_q <= IDLE;
      buf_q   <= '0;
      fill_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_bpc_bit_unpacker.sv
// Bench for bpc_bit_unpacker: directed scenarios plus random traffic, all
// checked against a bit-queue reference model of the stream.
module tb_bpc_bit_unpacker;

  localparam int IN_W    = 8;
  localparam int MAX_LEN = 16;
  localparam int BUF_W   = MAX_LEN + IN_W;
  localparam int FILL_W  = $clog2(BUF_W + 1);
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic               clr_i = 1'b0;
  logic [IN_W-1:0]    data_i = '0;
  logic               vld_i = 1'b0;
  logic               last_i = 1'b0;
  logic               rdy_o;
  logic [MAX_LEN-1:0] data_o;
  logic [FILL_W-1:0]  fill_o;
  logic               vld_o;
  logic               last_o;
  logic [LEN_W-1:0]   len_i = '0;
  logic               rdy_i = 1'b0;
  logic               err_o;

  int n_cmp = 0;
  int n_err = 0;
  int n_words = 0;

  // Reference model: the buffered stream as a plain queue of bits, oldest first.
  bit mq[$];
  bit m_drain;
  bit m_err;

  bpc_bit_unpacker #(
    .IN_W    (IN_W),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (clr_i),
    .data_i (data_i),
    .vld_i  (vld_i),
    .last_i (last_i),
    .rdy_o  (rdy_o),
    .data_o (data_o),
    .fill_o (fill_o),
    .vld_o  (vld_o),
    .last_o (last_o),
    .len_i  (len_i),
    .rdy_i  (rdy_i),
    .err_o  (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    vld_i  = 1'b0;
    data_i = '0;
    last_i = 1'b0;
    rdy_i  = 1'b0;
    len_i  = '0;
    clr_i  = 1'b0;
    rst_i  = 1'b0;
  endtask

  // One clock: drive inputs, compare outputs with the model, advance the model.
  task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic r,
                       input logic [4:0] len, input logic c, input logic rs);
    logic [15:0] ed;
    int fsz;
    int take;
    logic ev, er, el, ab;
    @(negedge clk_i);
    vld_i = v; data_i = d; last_i = l; rdy_i = r; len_i = len; clr_i = c; rst_i = rs;
    #1;
    fsz = mq.size();
    ab  = rs | c;
    ed  = '0;
    for (int i = 0; i < 16; i++) if (i < fsz) ed[15-i] = mq[i];
    ev = !ab && (fsz >= 16 || (m_drain && fsz > 0));
    er = !ab && !m_drain && fsz <= 16;
    el = ev && m_drain && fsz <= 16;
    chk("fill", 32'(fill_o), 32'(fsz));
    chk("data", 32'(data_o), 32'(ed));
    chk("vld", 32'(vld_o), 32'(ev));
    chk("rdy", 32'(rdy_o), 32'(er));
    chk("last", 32'(last_o), 32'(el));
    chk("err", 32'(err_o), 32'(m_err));
    chk("fill_bound", 32'(fill_o <= 5'd24), 32'd1);
    @(posedge clk_i);
    if (ab) begin
      mq.delete();
      m_drain = 1'b0;
      m_err   = 1'b0;
    end else begin
      if (ev && r) begin
        if (int'(len) > fsz) m_err = 1'b1;
        take = (int'(len) > fsz) ? fsz : int'(len);
        repeat (take) void'(mq.pop_front());
      end
      if (v && er) begin
        for (int i = 7; i >= 0; i--) mq.push_back(d[i]);
        if (l) m_drain = 1'b1;
        n_words++;
        $display("word %0d: 0x%02h last=%0b fill=%0d", n_words, d, l, mq.size());
      end
      if (m_drain && mq.size() == 0) m_drain = 1'b0;
    end
    #1;
    drive_idle();
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk_i);
    drive_idle();
    rst_i = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    mq.delete();
    m_drain = 1'b0;
    m_err   = 1'b0;
    cycle(0, 8'h00, 0, 0, 5'd0, 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    // Reset state
    reset_dut();
    chk("rst_fill", 32'(fill_o), 32'd0);
    chk("rst_vld", 32'(vld_o), 32'd0);
    chk("rst_rdy", 32'(rdy_o), 32'd1);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_last", 32'(last_o), 32'd0);

    // Fill to a full window, then past it
    cycle(1, 8'hA5, 0, 0, 5'd0, 0, 0);
    cycle(1, 8'h3C, 0, 0, 5'd0, 0, 0);
    chk("s1_fill16", 32'(fill_o), 32'd16);
    chk("s1_vld", 32'(vld_o), 32'd1);
    chk("s1_data", 32'(data_o), 32'hA53C);
    cycle(1, 8'hFF, 0, 0, 5'd0, 0, 0);
    chk("s1_fill24", 32'(fill_o), 32'd24);
    chk("s1_rdy", 32'(rdy_o), 32'd0);

    // Push and consume in the same cycle
    reset_dut();
    cycle(1, 8'hA5, 0, 0, 5'd0, 0, 0);
    cycle(1, 8'h3C, 0, 0, 5'd0, 0, 0);
    cycle(1, 8'h0F, 0, 1, 5'd3, 0, 0);
    chk("s2_fill", 32'(fill_o), 32'd21);
    chk("s2_data", 32'(data_o), 32'h29E0);

    // Single-word stream and drain back to idle
    reset_dut();
    cycle(1, 8'h80, 1, 0, 5'd0, 0, 0);
    chk("s3_vld", 32'(vld_o), 32'd1);
    chk("s3_last", 32'(last_o), 32'd1);
    chk("s3_data", 32'(data_o), 32'h8000);
    chk("s3_fill", 32'(fill_o), 32'd8);
    cycle(0, 8'h00, 0, 1, 5'd8, 0, 0);
    chk("s3_fill0", 32'(fill_o), 32'd0);
    chk("s3_vld0", 32'(vld_o), 32'd0);
    chk("s3_rdy", 32'(rdy_o), 32'd1);

    // Over-consumption in drain is sticky until clear
    reset_dut();
    cycle(1, 8'hE0, 1, 0, 5'd0, 0, 0);
    cycle(0, 8'h00, 0, 1, 5'd5, 0, 0);
    chk("s4_fill3", 32'(fill_o), 32'd3);
    chk("s4_err0", 32'(err_o), 32'd0);
    cycle(0, 8'h00, 0, 1, 5'd5, 0, 0);
    chk("s4_fill0", 32'(fill_o), 32'd0);
    chk("s4_err1", 32'(err_o), 32'd1);
    cycle(1, 8'h12, 0, 0, 5'd0, 0, 0);
    cycle(0, 8'h00, 0, 0, 5'd0, 0, 0);
    chk("s4_err_hold", 32'(err_o), 32'd1);
    cycle(0, 8'h00, 0, 0, 5'd0, 1, 0);
    chk("s4_err_clr", 32'(err_o), 32'd0);

    // Clear while a word is offered
    reset_dut();
    cycle(1, 8'hA5, 0, 0, 5'd0, 0, 0);
    cycle(1, 8'h3C, 0, 0, 5'd0, 0, 0);
    cycle(1, 8'h11, 0, 1, 5'd4, 0, 0);
    chk("s5_fill20", 32'(fill_o), 32'd20);
    cycle(1, 8'h77, 0, 0, 5'd0, 1, 0);
    chk("s5_fill0", 32'(fill_o), 32'd0);
    chk("s5_vld0", 32'(vld_o), 32'd0);
    chk("s5_err0", 32'(err_o), 32'd0);
    chk("s5_rdy", 32'(rdy_o), 32'd1);

    // Random traffic
    reset_dut();
    n_words = 0;
    cyc = 0;
    while (n_words < 200 && cyc < 6000) begin
      cycle(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 16)), ($urandom_range(0, 99) == 0), 1'b0);
      cyc++;
    end
    chk("rand_words", 32'(n_words >= 200), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
